// File: rtl/trace_cap_pkg.sv
// Shared definitions for the trace capture buffer: state encoding, timestamp width, entry width.
// Entry width grows by TS_W when TRACE_CAP_TIMESTAMP_EN is defined.
package trace_cap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TS_W = 16;

  function automatic int entry_w(input int data_w);
`ifdef TRACE_CAP_TIMESTAMP_EN
    return data_w + TS_W;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/trace_cap_ram.sv
// Simple dual-port storage for trace entries: one write port, one registered read port.
module trace_cap_ram #(
  parameter int ENTRY_W = 36,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_capture_buf.sv
// Circular trace recorder: captures while armed, freezes a post-trap window, streams out oldest-first.
// Define TRACE_CAP_TIMESTAMP_EN to prefix every entry with a 16-bit free-running cycle timestamp.
module trace_capture_buf
  import trace_cap_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int DEPTH = 256,
  parameter int POST_TRIG = 16,
  localparam int ENTRY_W = entry_w(DATA_W),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_i,
  input  logic               trace_valid_i,
  input  logic [DATA_W-1:0]  trace_data_i,
  input  logic               trap_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic [1:0]         state_o,
  output logic [AW:0]        fill_o,
  output logic               wrapped_o
);

  state_t             state, state_nxt;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        fill;
  logic [AW:0]        post_cnt;
  logic [AW:0]        post_cnt_inc;
  logic               wrapped;
  logic               ram_vld;
  logic [ENTRY_W-1:0] ram_rd_data;
  logic [ENTRY_W-1:0] wr_data;
  logic               wr_en;
  logic               xfer;
  logic               adv;
  logic               issue;
  logic [AW:0]        in_flight;
  logic [AW:0]        unissued;
  logic [AW-1:0]      rd_addr;
  logic               rearm;

`ifdef TRACE_CAP_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (!rst) ts <= '0;
    else      ts <= ts + 1'b1;
  end

  assign wr_data = {ts, trace_data_i};
`else
  assign wr_data = trace_data_i;
`endif

  assign wr_en        = (state == ARMED || state == POST) && trace_valid_i;
  assign xfer         = rd_valid_o && rd_ready_i;
  assign adv          = !rd_valid_o || rd_ready_i;
  assign rearm        = (state == IDLE || state == DONE) && arm_i;
  assign post_cnt_inc = post_cnt + 1'b1;

  // Entries not yet fetched are always the newest ones, so the next read
  // address falls out of wr_ptr directly; at DONE entry it equals wr_ptr - fill.
  assign in_flight = (AW+1)'(ram_vld) + (AW+1)'(rd_valid_o);
  assign unissued  = fill - in_flight;
  assign issue     = (state == DONE) && adv && (unissued != '0);
  assign rd_addr   = wr_ptr - unissued[AW-1:0];

  trace_cap_ram #(
    .ENTRY_W(ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en  (issue),
    .rd_addr(rd_addr),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (arm_i) state_nxt = ARMED;
      ARMED: if (trap_i) state_nxt = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (trace_valid_i && post_cnt_inc == (AW+1)'(POST_TRIG)) state_nxt = DONE;
      DONE: begin
        if (arm_i) state_nxt = ARMED;
        else if (fill == '0 || (fill == (AW+1)'(1) && xfer)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      wrapped    <= 1'b0;
      post_cnt   <= '0;
      ram_vld    <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      state <= state_nxt;
      if (rearm) begin
        wr_ptr     <= '0;
        fill       <= '0;
        wrapped    <= 1'b0;
        post_cnt   <= '0;
        ram_vld    <= 1'b0;
        rd_valid_o <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill == (AW+1)'(DEPTH)) wrapped <= 1'b1;
          else                        fill    <= fill + 1'b1;
          if (state == POST) post_cnt <= post_cnt_inc;
        end
        if (xfer) fill <= fill - 1'b1;
        // RAM output and output register advance together; a stall freezes both.
        if (adv) begin
          ram_vld    <= issue;
          rd_valid_o <= ram_vld;
          if (ram_vld) rd_data_o <= ram_rd_data;
        end
      end
    end
  end

  assign state_o   = state;
  assign fill_o    = fill;
  assign wrapped_o = wrapped;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Scoreboard bench: two recorders (POST_TRIG=2 and 0) share stimulus; a per-instance reference
// model queues each frozen window and a monitor pops it on every readout handshake.
`timescale 1ns/1ps
module tb_trace_capture_buf;
  import trace_cap_pkg::*;

  localparam int DW = 36;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(DW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arm = 1'b0;
  logic tv = 1'b0;
  logic trap = 1'b0;
  logic rdy = 1'b0;
  logic [DW-1:0] td = '0;
  bit chk_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef TRACE_CAP_TIMESTAMP_EN
  logic [15:0] tb_ts;
  always @(posedge clk) tb_ts <= (!rst) ? 16'd0 : tb_ts + 16'd1;
`endif

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int PT = (g == 0) ? 2 : 0;
    logic          vld;
    logic [EW-1:0] dat;
    logic [1:0]    st;
    logic [AW:0]   fill;
    logic          wrp;

    trace_capture_buf #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(PT)) u_dut (
      .clk(clk), .rst(rst), .arm_i(arm), .trace_valid_i(tv), .trace_data_i(td), .trap_i(trap),
      .rd_valid_o(vld), .rd_ready_i(rdy), .rd_data_o(dat), .state_o(st), .fill_o(fill),
      .wrapped_o(wrp)
    );

    // Reference model: 0 idle, 1 armed, 2 post, 3 done; words holds the captured history.
    int m_st = 0;
    int m_fill = 0;
    int m_post = 0;
    int m_age = 0;
    bit m_wrap = 1'b0;
    int n_xfer = 0;
    logic [EW-1:0] m_words[$];
    logic [EW-1:0] sb[$];

    task automatic store(input logic [EW-1:0] e);
      m_words.push_back(e);
      if (m_words.size() > DEPTH) begin
        void'(m_words.pop_front());
        m_wrap = 1'b1;
      end
      m_fill = m_words.size();
    endtask

    task automatic enter_done();
      m_st = 3;
      m_age = 0;
      m_fill = m_words.size();
      foreach (m_words[i]) sb.push_back(m_words[i]);
    endtask

    task automatic clear_capture();
      m_fill = 0;
      m_wrap = 1'b0;
      m_post = 0;
      m_words.delete();
      sb.delete();
    endtask

    initial forever begin
      logic [EW-1:0] ent;
      @(negedge clk);
      if (chk_en) begin
        check("state", g, 64'(st), 64'(m_st));
        check("fill", g, 64'(fill), 64'(m_fill));
        check("wrapped", g, 64'(wrp), 64'(m_wrap));
        check("rd_valid", g, 64'(vld), 64'(m_st == 3 && m_age >= 2 && m_fill > 0));
      end
`ifdef TRACE_CAP_TIMESTAMP_EN
      ent = {tb_ts, td};
`else
      ent = td;
`endif
      if (!rst) begin
        m_st = 0;
        clear_capture();
      end else begin
        case (m_st)
          0: if (arm) begin m_st = 1; clear_capture(); end
          1: begin
            if (tv) store(ent);
            if (trap) begin
              m_post = 0;
              if (PT == 0) enter_done();
              else m_st = 2;
            end
          end
          2: if (tv) begin
            store(ent);
            m_post++;
            if (m_post == PT) enter_done();
          end
          default: begin
            m_age++;
            if (arm) begin m_st = 1; clear_capture(); end
            else if (m_fill == 0) m_st = 0;
            else if (vld && rdy) begin
              m_fill--;
              if (m_fill == 0) m_st = 0;
            end
          end
        endcase
      end
    end

    initial begin
      logic [EW-1:0] hold_dat;
      logic [EW-1:0] exp;
      bit hold;
      hold = 1'b0;
      hold_dat = '0;
      forever begin
        @(negedge clk);
        if (chk_en && hold && vld) check("stall_stable", g, 64'(dat), 64'(hold_dat));
        hold = 1'b0;
        if (chk_en && vld && rst) begin
          if (rdy) begin
            n_xfer++;
            check("sb_nonempty", g, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
              exp = sb.pop_front();
              check("rd_data", g, 64'(dat), 64'(exp));
            end
          end else begin
            hold = 1'b1;
            hold_dat = dat;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic v, input logic t, input logic [DW-1:0] d);
    arm = a; tv = v; trap = t; td = d;
    cyc();
    arm = 1'b0; tv = 1'b0; trap = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic drain(input bit alternate);
    int n;
    n = 0;
    while (!(g_inst[0].st == 2'd0 && g_inst[1].st == 2'd0) && n < 200) begin
      rdy = alternate ? ~rdy : 1'b1;
      cyc();
      n++;
    end
    rdy = 1'b0;
    check("drain_idle", 0, 64'(g_inst[0].st), 64'd0);
    check("drain_idle", 1, 64'(g_inst[1].st), 64'd0);
    check("sb_drained", 0, 64'(g_inst[0].sb.size()), 64'd0);
    check("sb_drained", 1, 64'(g_inst[1].sb.size()), 64'd0);
  endtask

`ifdef TRACE_CAP_TIMESTAMP_EN
  task automatic wait_ts(input logic [15:0] t);
    int n;
    n = 0;
    while (tb_ts != t && n < 300) begin cyc(); n++; end
    check("ts_reached", 0, 64'(tb_ts), 64'(t));
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_rd_data", i, (i == 0) ? 64'(g_inst[0].dat) : 64'(g_inst[1].dat), 64'd0);
    end

    // Plain capture: 1..5, 6 with trap, then 7, 8.
    rdy = 1'b1;
    drive(1, 0, 0, '0);
    for (int i = 1; i <= 5; i++) drive(0, 1, 0, DW'(i));
    drive(0, 1, 1, DW'(6));
    drive(0, 1, 0, DW'(7));
    drive(0, 1, 0, DW'(8));
    drain(1'b0);

    // Wrap: 0x10..0x1C with trap on 0x1C, then 0x1D, 0x1E.
    drive(1, 0, 0, '0);
    for (int i = 'h10; i <= 'h1C; i++) drive(0, 1, (i == 'h1C), DW'(i));
    drive(0, 1, 0, DW'('h1D));
    drive(0, 1, 0, DW'('h1E));
    drain(1'b0);

    // Trap cycle without a valid word.
    drive(1, 0, 0, '0);
    drive(0, 1, 0, DW'('hA));
    drive(0, 1, 0, DW'('hB));
    drive(0, 0, 1, '0);
    drive(0, 1, 0, DW'('hC));
    drive(0, 1, 0, DW'('hD));
    drain(1'b0);

    // Backpressure: alternating ready while reading out.
    g_inst[0].n_xfer = 0;
    g_inst[1].n_xfer = 0;
    rdy = 1'b0;
    drive(1, 0, 0, '0);
    for (int i = 1; i <= 8; i++) drive(0, 1, (i == 6), DW'('h40 + i));
    drain(1'b1);
    check("xfer_count", 0, 64'(g_inst[0].n_xfer), 64'd8);
    check("xfer_count", 1, 64'(g_inst[1].n_xfer), 64'd6);

    // Reset while the first instance sits in POST, then recover.
    drive(1, 0, 0, '0);
    drive(0, 1, 0, DW'('h71));
    drive(0, 1, 1, DW'('h72));
    drive(0, 1, 0, DW'('h73));
    check("pre_rst_post", 0, 64'(g_inst[0].st), 64'd2);
    do_reset();
    check("rst_rd_data", 0, 64'(g_inst[0].dat), 64'd0);
    check("rst_rd_data", 1, 64'(g_inst[1].dat), 64'd0);
    rdy = 1'b1;
    drive(1, 0, 0, '0);
    for (int i = 1; i <= 4; i++) drive(0, 1, (i == 2), DW'('h80 + i));
    drain(1'b0);

    // Re-arm while a readout is pending, then arm+trap together and trap held into ARMED.
    drive(1, 0, 0, '0);
    for (int i = 1; i <= 5; i++) drive(0, 1, (i == 3), DW'('h90 + i));
    begin
      int n;
      n = 0;
      while (!g_inst[0].vld && n < 20) begin cyc(); n++; end
      check("pending_valid", 0, 64'(g_inst[0].vld), 64'd1);
    end
    drive(1, 0, 0, '0);
    drive(0, 0, 1, '0);
    drive(0, 1, 0, DW'('hA1));
    drive(0, 1, 0, DW'('hA2));
    drain(1'b0);
    drive(1, 0, 1, '0);
    drive(0, 1, 1, DW'('h55));
    drive(0, 1, 0, DW'('h56));
    drive(0, 1, 0, DW'('h57));
    drain(1'b0);

    // Randomised traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      logic a;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        a = ($urandom_range(0, 29) == 0);
        rdy = a ? 1'b0 : 1'($urandom_range(0, 1));
        drive(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              DW'({$urandom(), $urandom()}));
      end
    end
    rdy = 1'b1;
    drive(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, DW'($urandom()));
    drain(1'b0);

`ifdef TRACE_CAP_TIMESTAMP_EN
    // Timestamped capture at cycles 100, 103 and 110 after reset.
    do_reset();
    rdy = 1'b1;
    drive(1, 0, 0, '0);
    wait_ts(16'd100);
    drive(0, 1, 0, DW'('hB1));
    wait_ts(16'd103);
    drive(0, 1, 0, DW'('hB2));
    wait_ts(16'd110);
    drive(0, 1, 0, DW'('hB3));
    drive(0, 0, 1, '0);
    drive(0, 1, 0, DW'('hB4));
    drive(0, 1, 0, DW'('hB5));
    drain(1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_capture_buf.md
Name: trace_capture_buf

Overview:
- Synthesizable, parametrised trace recorder for the picorv32 demo system; replaces bench-only trace file dumping with on-chip capture.
- Records core trace words into a circular buffer while armed and freezes a post-trigger window after trap.
- Offers oldest-first stream readout for a debug bridge or testbench.

Parameters:
- DATA_W, 36, trace word width.
- DEPTH, 256, buffer entries; power of two, minimum 4.
- POST_TRIG, 16, valid words captured after trap; 0 to DEPTH-1 allowed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- arm_i  in  1  start or restart capture (level sampled on posedge).
- trace_valid_i  in  1  trace word valid.
- trace_data_i  in  DATA_W  trace word.
- trap_i  in  1  trigger, level.
- rd_valid_o  out  1  readout word available.
- rd_ready_i  in  1  readout accept.
- rd_data_o  out  ENTRY_W  readout word; ENTRY_W = DATA_W, or DATA_W+TS_W with timestamps.
- state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- fill_o  out  $clog2(DEPTH)+1  stored entries.
- wrapped_o  out  1  at least one entry was overwritten.

Behaviour:
- Reset is synchronous, active-low, on posedge clk: rst=0 gives state IDLE, wr_ptr=0, fill_o=0, wrapped_o=0, rd_valid_o=0, rd_data_o=0. RAM is not cleared. Reset mid-operation aborts immediately.
- IDLE:
  - arm_i -> ARMED; clears fill, wr_ptr, wrapped.
  - trap_i is ignored.
  - arm_i and trap_i together: arm wins, trap is ignored that cycle.
- ARMED:
  - Each trace_valid_i writes mem[wr_ptr] and increments wr_ptr (mod DEPTH).
  - fill saturates at DEPTH. A write at fill==DEPTH overwrites the oldest entry and sets wrapped_o (sticky until re-arm).
  - trap_i=1 -> POST, or DONE if POST_TRIG==0. A valid word in the same cycle as trap is stored and counts as pre-trigger.
  - arm_i is ignored.
- POST:
  - Stores valid words as in ARMED; post counter increments per stored word.
  - The word that makes the counter reach POST_TRIG is stored, then the next state is DONE.
  - trap_i and arm_i are ignored.
- DONE:
  - Writes are blocked. Read pointer is initialised to oldest = wr_ptr - fill (mod DEPTH).
  - rd_valid_o=1 while fill>0. rd_data_o presents the oldest entry.
  - Handshake: a transfer occurs when rd_valid_o & rd_ready_i. On transfer, the pointer advances, fill decrements, and the next word is presented on the following cycle with no bubble. This requires a prefetch register over a 1-cycle synchronous RAM read.
  - rd_valid_o first asserts 2 cycles after entering DONE (RAM latency plus prefetch).
  - rd_data_o is stable while rd_valid_o & !rd_ready_i.
  - When fill reaches 0: rd_valid_o drops the next cycle and state -> IDLE.
  - arm_i in DONE discards the remaining entries and goes to ARMED; rd_valid_o drops the same cycle arm is sampled.
- Trap that arrives already high at arming is ignored until the first cycle in ARMED.
- fill_o and state_o are registered and reflect post-edge values.

Optional Feature:
- Macro TRACE_CAP_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 16-bit cycle counter (TS_W=16), cleared by reset and wrapping at 0xFFFF.
  - Each entry stores {timestamp, trace_data}; ENTRY_W = DATA_W+16, timestamp in the MSBs.
  - Timestamp is the counter value in the cycle trace_valid_i is sampled.
- Undefined:
  - No counter; ENTRY_W = DATA_W.

Decomposition:
- Package trace_cap_pkg:
  - state encoding constants IDLE/ARMED/POST/DONE;
  - TS_W=16;
  - ENTRY_W derivation macro/function.
- Sub-module trace_cap_ram:
  - simple dual-port RAM, one write port, one synchronous read port;
  - parameters ENTRY_W and DEPTH;
  - infers block RAM.
- All control lives in the top.

Test Plan:
- DEPTH=8, POST_TRIG=2. Arm, push 0x1..0x5, push 0x6 with trap_i, then push 0x7, 0x8. Required: state DONE, fill_o=8, wrapped_o=0, readout 0x1..0x8 in order, then state IDLE.
- Same config, wrap case. Push 0x10..0x1C, trap on 0x1C, then push 0x1D, 0x1E. Required: fill_o=8, wrapped_o=1, readout 0x17..0x1E.
- POST_TRIG=0. Push 0xA and 0xB, trap with no valid in the trap cycle, then further valids 0xC and 0xD. Required: DONE one cycle after trap, readout 0xA, 0xB only.
- Backpressure. DONE with 8 entries, rd_ready_i alternating 1/0 each cycle. Required: exactly 8 transfers, no duplicates or gaps, rd_data_o stable while stalled.
- Reset mid-POST: assert rst=0 for one cycle. Required: state_o=0, fill_o=0, wrapped_o=0, rd_valid_o=0 next cycle. Re-arming recovers normally.
- With TRACE_CAP_TIMESTAMP_EN, 100 cycles after reset release. Push valids at timestamps 100, 103, 110, then trap. Required: readout MSBs 0x0064, 0x0067, 0x006E.
